// File: rtl/sum_pkg.sv
// Shared definitions for the adder stage and its window accumulator.
package sum_pkg;

    localparam int SUM_W = 9;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // The upstream odd flag must agree with the LSB of the sum it accompanies.
    function automatic logic parity_mismatch(input logic is_odd, input logic sum_lsb);
        return is_odd ^ sum_lsb;
    endfunction

endpackage

// File: rtl/sum_window_accum.sv
// Accumulates adder sums over fixed windows and hands each window's totals
// downstream over a valid/ready handshake; flags odd-flag/sum disagreement.
module sum_window_accum #(
    parameter int SUM_W  = sum_pkg::SUM_W,
    parameter int WINDOW = 4,
    parameter int ACC_W  = SUM_W + $clog2(WINDOW),
    parameter int CNT_W  = $clog2(WINDOW) + 1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [SUM_W-1:0] sum_i,
    input  logic             is_odd_i,
    output logic             ready_o,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [ACC_W-1:0] total_o,
    output logic [CNT_W-1:0] odd_count_o,
    output logic [CNT_W-1:0] samples_o,
    output logic             err_o
);
    import sum_pkg::*;

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   odd_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               accept_s;
    logic               close_s;
    logic [ACC_W-1:0]   acc_upd_s;
    logic [CNT_W-1:0]   odd_upd_s;
    logic [CNT_W-1:0]   cnt_upd_s;

    // Handshake outputs come straight from the registered state.
    assign ready_o = (state_r == ACCUM);
    assign valid_o = (state_r == HOLD);

    // Post-accept running values and the window close decision.
    always_comb begin
        accept_s  = valid_i && (state_r == ACCUM);
        acc_upd_s = acc_r;
        odd_upd_s = odd_r;
        cnt_upd_s = cnt_r;
        close_s   = 1'b0;
        if (accept_s) begin
            acc_upd_s = acc_r + ACC_W'(sum_i);
            odd_upd_s = odd_r + CNT_W'(is_odd_i);
            cnt_upd_s = cnt_r + CNT_W'(1'b1);
        end else begin
            acc_upd_s = acc_r;
            odd_upd_s = odd_r;
            cnt_upd_s = cnt_r;
        end
        // A flush with nothing accepted so far and nothing arriving is a no-op.
        if (state_r == ACCUM) begin
            close_s = (accept_s && (cnt_r == CNT_W'(WINDOW - 1)))
                   || (flush_i && ((cnt_r != {CNT_W{1'b0}}) || accept_s));
        end else begin
            close_s = 1'b0;
        end
    end

    // Window FSM, accumulators, result registers and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_r     <= ACCUM;
            acc_r       <= {ACC_W{1'b0}};
            odd_r       <= {CNT_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            total_o     <= {ACC_W{1'b0}};
            odd_count_o <= {CNT_W{1'b0}};
            samples_o   <= {CNT_W{1'b0}};
            err_o       <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    acc_r <= acc_upd_s;
                    odd_r <= odd_upd_s;
                    cnt_r <= cnt_upd_s;
                    if (accept_s && parity_mismatch(is_odd_i, sum_i[0])) begin
                        err_o <= 1'b1;
                    end
                    if (close_s) begin
                        total_o     <= acc_upd_s;
                        odd_count_o <= odd_upd_s;
                        samples_o   <= cnt_upd_s;
                        state_r     <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        acc_r   <= {ACC_W{1'b0}};
                        odd_r   <= {CNT_W{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ACCUM;
                    end
                end
                default: begin
                    state_r <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_window_accum.sv
// Self-checking bench for sum_window_accum: directed scenarios plus random
// traffic against a queue-based window model.
module tb_sum_window_accum;

    localparam int SUM_W  = 9;
    localparam int WINDOW = 4;
    localparam int ACC_W  = SUM_W + $clog2(WINDOW);
    localparam int CNT_W  = $clog2(WINDOW) + 1;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             valid_i = 1'b0;
    logic [SUM_W-1:0] sum_i = '0;
    logic             is_odd_i = 1'b0;
    logic             ready_o;
    logic             flush_i = 1'b0;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [ACC_W-1:0] total_o;
    logic [CNT_W-1:0] odd_count_o;
    logic [CNT_W-1:0] samples_o;
    logic             err_o;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: the open window is simply the list of accepted samples.
    int q_sum[$];
    bit q_odd[$];
    bit m_hold  = 1'b0;
    bit m_err   = 1'b0;
    int m_total = 0;
    int m_oddc  = 0;
    int m_samp  = 0;

    sum_window_accum #(
        .SUM_W(SUM_W), .WINDOW(WINDOW), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_i(reset_i), .valid_i(valid_i), .sum_i(sum_i),
        .is_odd_i(is_odd_i), .ready_o(ready_o), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .total_o(total_o),
        .odd_count_o(odd_count_o), .samples_o(samples_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, clock, settle 1 time unit.
    task automatic step(input bit v, input int s, input bit o, input bit f,
                        input bit r, input bit rst);
        int tot;
        int oc;
        reset_i  = rst;
        valid_i  = v;
        sum_i    = s[SUM_W-1:0];
        is_odd_i = o;
        flush_i  = f;
        ready_i  = r;
        if (rst) begin
            q_sum.delete(); q_odd.delete();
            m_hold = 1'b0; m_err = 1'b0;
            m_total = 0; m_oddc = 0; m_samp = 0;
        end else if (!m_hold) begin
            if (v) begin
                q_sum.push_back(s % 512);
                q_odd.push_back(o);
                if (o != ((s % 512) % 2 == 1)) m_err = 1'b1;
            end
            if ((v && q_sum.size() == WINDOW) || (f && q_sum.size() > 0)) begin
                tot = 0; oc = 0;
                foreach (q_sum[i]) begin
                    tot += q_sum[i];
                    if (q_odd[i]) oc++;
                end
                m_total = tot; m_oddc = oc; m_samp = q_sum.size();
                m_hold = 1'b1;
            end
        end else if (r) begin
            q_sum.delete(); q_odd.delete();
            m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        n_checks++; if (ready_o !== 1'b1) begin n_fails++; $display("FAIL reset_ready got %b want 1", ready_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_checks++; if (total_o !== '0 || odd_count_o !== '0 || samples_o !== '0)
            begin n_fails++; $display("FAIL reset_results got %0d/%0d/%0d want 0/0/0", total_o, odd_count_o, samples_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fails++; $display("FAIL reset_err got %b want 0", err_o); end
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        step(1, 1, 1, 0, 1, 0);
        step(1, 4, 0, 0, 1, 0);
        step(1, 19, 1, 0, 1, 0);
        n_checks++; if (valid_o !== 1'b0) begin n_fails++; $display("FAIL basic_early_valid got %b want 0", valid_o); end
        step(1, 20, 0, 0, 1, 0);
        n_checks++; if (valid_o !== 1'b1 || ready_o !== 1'b0)
            begin n_fails++; $display("FAIL basic_latency got valid=%b ready=%b want 1/0", valid_o, ready_o); end
        n_checks++; if (total_o !== 11'd44 || odd_count_o !== 3'd2 || samples_o !== 3'd4 || err_o !== 1'b0)
            begin n_fails++; $display("FAIL basic_result got %0d/%0d/%0d err=%b want 44/2/4 err=0", total_o, odd_count_o, samples_o, err_o); end
        step(0, 0, 0, 0, 1, 0);
        n_checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || total_o !== 11'd44)
            begin n_fails++; $display("FAIL basic_handshake got ready=%b valid=%b total=%0d want 1/0/44", ready_o, valid_o, total_o); end
    endtask

    task automatic test_back_pressure();
        step(1, 1, 1, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0);
        step(1, 19, 1, 0, 0, 0);
        step(1, 20, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 11, 1, 0, 0, 0);
            n_checks++; if (valid_o !== 1'b1 || ready_o !== 1'b0 || total_o !== 11'd44)
                begin n_fails++; $display("FAIL bp_hold[%0d] got valid=%b ready=%b total=%0d want 1/0/44", i, valid_o, ready_o, total_o); end
        end
        step(1, 11, 1, 0, 1, 0);
        n_checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0)
            begin n_fails++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", ready_o, valid_o); end
        step(1, 11, 1, 0, 1, 0);
        step(1, 2, 0, 0, 1, 0);
        step(1, 3, 1, 0, 1, 0);
        step(1, 4, 0, 0, 1, 0);
        n_checks++; if (valid_o !== 1'b1 || total_o !== 11'd20 || odd_count_o !== 3'd2 || samples_o !== 3'd4)
            begin n_fails++; $display("FAIL bp_next_window got valid=%b %0d/%0d/%0d want 1 20/2/4", valid_o, total_o, odd_count_o, samples_o); end
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_flush();
        step(1, 9, 1, 0, 1, 0);
        step(1, 20, 0, 0, 1, 0);
        step(1, 11, 1, 1, 1, 0);
        n_checks++; if (valid_o !== 1'b1 || total_o !== 11'd40 || odd_count_o !== 3'd2 || samples_o !== 3'd3)
            begin n_fails++; $display("FAIL flush_partial got valid=%b %0d/%0d/%0d want 1 40/2/3", valid_o, total_o, odd_count_o, samples_o); end
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        n_checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1)
            begin n_fails++; $display("FAIL flush_empty got valid=%b ready=%b want 0/1", valid_o, ready_o); end
        step(0, 0, 0, 0, 1, 0);
        n_checks++; if (valid_o !== 1'b0 || samples_o !== 3'd3)
            begin n_fails++; $display("FAIL flush_empty_after got valid=%b samples=%0d want 0/3", valid_o, samples_o); end
    endtask

    task automatic test_parity();
        step(1, 6, 1, 0, 1, 0);
        n_checks++; if (err_o !== 1'b1) begin n_fails++; $display("FAIL parity_set got %b want 1", err_o); end
        step(1, 5, 1, 0, 1, 0);
        step(1, 2, 0, 0, 1, 0);
        step(1, 3, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        n_checks++; if (err_o !== 1'b1 || total_o !== 11'd16 || odd_count_o !== 3'd3)
            begin n_fails++; $display("FAIL parity_sticky got err=%b total=%0d odd=%0d want 1/16/3", err_o, total_o, odd_count_o); end
        step(0, 0, 0, 0, 0, 1);
        n_checks++; if (err_o !== 1'b0) begin n_fails++; $display("FAIL parity_clear got %b want 0", err_o); end
    endtask

    task automatic test_max();
        for (int i = 0; i < WINDOW; i++) step(1, 511, 1, 0, 0, 0);
        n_checks++; if (total_o !== 11'd2044 || odd_count_o !== 3'd4 || samples_o !== 3'd4 || err_o !== 1'b0)
            begin n_fails++; $display("FAIL max_result got %0d/%0d/%0d err=%b want 2044/4/4 err=0", total_o, odd_count_o, samples_o, err_o); end
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        step(1, 5, 1, 0, 1, 0);
        step(1, 6, 0, 0, 1, 0);
        step(1, 7, 1, 0, 1, 1);
        n_checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || total_o !== '0 || odd_count_o !== '0 || samples_o !== '0 || err_o !== 1'b0)
            begin n_fails++; $display("FAIL reset_mid got ready=%b valid=%b %0d/%0d/%0d err=%b want 1/0 0/0/0 0", ready_o, valid_o, total_o, odd_count_o, samples_o, err_o); end
        step(1, 5, 1, 0, 1, 0);
        step(1, 6, 0, 0, 1, 0);
        step(1, 7, 1, 0, 1, 0);
        n_checks++; if (valid_o !== 1'b0) begin n_fails++; $display("FAIL reset_mid_fresh got valid=%b want 0", valid_o); end
        step(1, 8, 0, 0, 1, 0);
        n_checks++; if (valid_o !== 1'b1 || total_o !== 11'd26 || odd_count_o !== 3'd2 || samples_o !== 3'd4)
            begin n_fails++; $display("FAIL reset_mid_window got valid=%b %0d/%0d/%0d want 1 26/2/4", valid_o, total_o, odd_count_o, samples_o); end
        step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        int s;
        bit o;
        for (int i = 0; i < 400; i++) begin
            s = int'($urandom_range(0, 511));
            o = s[0] ^ ($urandom_range(0, 31) == 0);
            step($urandom_range(0, 3) != 0, s, o, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
            n_checks++;
            if (ready_o !== !m_hold || valid_o !== m_hold || err_o !== m_err
                || total_o !== ACC_W'(m_total) || odd_count_o !== CNT_W'(m_oddc)
                || samples_o !== CNT_W'(m_samp)) begin
                n_fails++;
                $display("FAIL random[%0d] got r=%b v=%b e=%b %0d/%0d/%0d want r=%b v=%b e=%b %0d/%0d/%0d",
                         i, ready_o, valid_o, err_o, total_o, odd_count_o, samples_o,
                         !m_hold, m_hold, m_err, m_total, m_oddc, m_samp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_flush();
        test_parity();
        test_max();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
